// File: rtl/trace_pkg.sv
// Commit-trace record format shared by the writer and its FIFO:
// kind encodings, 38-bit record layout {kind, reg, addr, data} and writer states.
package trace_pkg;

   localparam logic [1:0] KIND_REG   = 2'd0;
   localparam logic [1:0] KIND_LOAD  = 2'd1;
   localparam logic [1:0] KIND_STORE = 2'd2;
   localparam logic [1:0] KIND_HALT  = 2'd3;

   localparam int REC_W    = 38;
   localparam int DATA_LSB = 0;
   localparam int ADDR_LSB = 16;
   localparam int REG_LSB  = 32;
   localparam int KIND_LSB = 36;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   function automatic logic [REC_W-1:0] make_rec(input logic [1:0]  kind,
                                                 input logic [3:0]  rnum,
                                                 input logic [15:0] addr,
                                                 input logic [15:0] data);
      return {kind, rnum, addr, data};
   endfunction

endpackage

// File: rtl/trace_fifo.sv
// DEPTH x 38 record FIFO: up to three writes per cycle into consecutive slots,
// one combinational read port at the head.
module trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            push_n,
   input  logic [2:0][REC_W-1:0] wr_rec,
   input  logic                  rd_ready,
   output logic                  rd_valid,
   output logic [REC_W-1:0]      head,
   output logic [PTR_W:0]        occupancy,
   output logic [PTR_W:0]        free
);

   logic [REC_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             pop;

   assign rd_valid  = (count_q != '0);
   assign pop       = rd_valid & rd_ready;
   assign head      = mem_q[rd_ptr_q];
   assign occupancy = count_q;
   // Space seen by this cycle's writes already includes the slot freed by this cycle's pop.
   assign free      = (PTR_W+1)'(DEPTH) - (count_q - (PTR_W+1)'(pop));

   assign wr_ptr_d  = wr_ptr_q + PTR_W'(push_n);
   assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
   assign count_d   = count_q - (PTR_W+1)'(pop) + (PTR_W+1)'(push_n);

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: the storage array has no reset; stale slots are never visible because count_q gates validity.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (i < int'(push_n)) begin
            mem_q[wr_ptr_q + PTR_W'(i)] <= wr_rec[i];
         end
      end
   end

endmodule

// File: rtl/commit_trace_writer.sv
// Turns per-cycle commit events into REG/LOAD/STORE/HALT trace records, buffers them
// in order, and keeps the architectural instruction and cycle counters.
module commit_trace_writer
   import trace_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int PTR_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_write,
   input  logic [3:0]  write_reg,
   input  logic [15:0] write_data,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        halt,
   input  logic [15:0] pc,
   output logic        rec_valid,
   input  logic        rec_ready,
   output logic [1:0]  rec_kind,
   output logic [3:0]  rec_reg,
   output logic [15:0] rec_addr,
   output logic [15:0] rec_data,
   output logic [31:0] inst_count,
   output logic [31:0] cycle_count,
   output logic        overflow,
   output logic        proto_err,
   output logic        done
);

   state_t               state_q, state_d;
   logic [31:0]          inst_q, inst_d, inst_inc;
   logic [31:0]          cyc_q, cyc_d;
   logic                 ovf_q, ovf_d;
   logic                 perr_q, perr_d;

   logic                 is_run;
   logic                 ev_reg, ev_load, ev_store, ev_halt;
   logic [1:0]           n_ev, push_n;
   logic                 fits;
   logic [2:0][REC_W-1:0] recs;
   logic [REC_W-1:0]     head;
   logic [PTR_W:0]       occupancy, free;

   assign is_run   = (state_q == ST_RUN);
   assign ev_reg   = is_run & reg_write;
   assign ev_load  = is_run & mem_read & ~mem_write;
   assign ev_store = is_run & mem_write;
   assign ev_halt  = is_run & halt;
   assign inst_inc = inst_q + 32'd1;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      recs = '0;
      n_ev = '0;
      if (ev_reg) begin
         recs[n_ev] = make_rec(KIND_REG, write_reg, 16'h0000, write_data);
         n_ev       = n_ev + 2'd1;
      end
      if (ev_load) begin
         recs[n_ev] = make_rec(KIND_LOAD, 4'h0, mem_addr, mem_rdata);
         n_ev       = n_ev + 2'd1;
      end
      if (ev_store) begin
         recs[n_ev] = make_rec(KIND_STORE, 4'h0, mem_addr, mem_wdata);
         n_ev       = n_ev + 2'd1;
      end
      if (ev_halt) begin
         recs[n_ev] = make_rec(KIND_HALT, 4'h0, pc, inst_inc[15:0]);
         n_ev       = n_ev + 2'd1;
      end
   end

   // A cycle's events go in whole or not at all.
   assign fits   = ((PTR_W+1)'(n_ev) <= free);
   assign push_n = fits ? n_ev : 2'd0;

   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      cyc_d   = cyc_q;
      ovf_d   = ovf_q | ~fits;
      perr_d  = perr_q | (is_run & mem_read & mem_write);
      if (is_run) begin
         cyc_d = cyc_q + 32'd1;
         if (halt | reg_write | mem_write) inst_d = inst_inc;
         if (ev_halt && fits) state_d = ST_HALTED;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
         inst_q  <= '0;
         cyc_q   <= '0;
         ovf_q   <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         cyc_q   <= cyc_d;
         ovf_q   <= ovf_d;
         perr_q  <= perr_d;
      end
   end

   trace_fifo #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_n    (push_n),
      .wr_rec    (recs),
      .rd_ready  (rec_ready),
      .rd_valid  (rec_valid),
      .head      (head),
      .occupancy (occupancy),
      .free      (free)
   );

   // Fields read as zero while empty so nothing stale leaks from the array.
   assign rec_kind    = rec_valid ? head[KIND_LSB +: 2]  : 2'd0;
   assign rec_reg     = rec_valid ? head[REG_LSB  +: 4]  : 4'd0;
   assign rec_addr    = rec_valid ? head[ADDR_LSB +: 16] : 16'd0;
   assign rec_data    = rec_valid ? head[DATA_LSB +: 16] : 16'd0;
   assign inst_count  = inst_q;
   assign cycle_count = cyc_q;
   assign overflow    = ovf_q;
   assign proto_err   = perr_q;
   assign done        = (state_q == ST_HALTED) && (occupancy == '0);

endmodule

// File: tb/tb_commit_trace_writer.sv
// Directed bench for commit_trace_writer: record ordering, overflow, protocol error,
// halt/drain and mid-stream reset, with hand-computed expectations.
module tb_commit_trace_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_write;
   logic [3:0]  write_reg;
   logic [15:0] write_data;
   logic        mem_read, mem_write;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        halt;
   logic [15:0] pc;
   logic        rec_valid, rec_ready;
   logic [1:0]  rec_kind;
   logic [3:0]  rec_reg;
   logic [15:0] rec_addr, rec_data;
   logic [31:0] inst_count, cycle_count;
   logic        overflow, proto_err, done;

   int vectors = 0;
   int miscompares = 0;

   commit_trace_writer #(.DEPTH(16), .PTR_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .reg_write   (reg_write),
      .write_reg   (write_reg),
      .write_data  (write_data),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .halt        (halt),
      .pc          (pc),
      .rec_valid   (rec_valid),
      .rec_ready   (rec_ready),
      .rec_kind    (rec_kind),
      .rec_reg     (rec_reg),
      .rec_addr    (rec_addr),
      .rec_data    (rec_data),
      .inst_count  (inst_count),
      .cycle_count (cycle_count),
      .overflow    (overflow),
      .proto_err   (proto_err),
      .done        (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reg_write  = 1'b0;
      write_reg  = 4'h0;
      write_data = 16'h0000;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = 16'h0000;
      mem_wdata  = 16'h0000;
      mem_rdata  = 16'h0000;
      halt       = 1'b0;
      pc         = 16'h0000;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("miscompare at %s", tag);
      end
   endtask

   // {valid, kind, reg, addr, data} of the head record.
   function automatic logic [63:0] exp_rec(input logic [1:0] k, input logic [3:0] r,
                                           input logic [15:0] a, input logic [15:0] d);
      return 64'({1'b1, k, r, a, d});
   endfunction

   function automatic logic [63:0] obs_rec();
      return 64'({rec_valid, rec_kind, rec_reg, rec_addr, rec_data});
   endfunction

   initial begin
      idle();
      rec_ready = 1'b0;
      rst       = 1'b1;
      tick();
      tick();
      check("rst_valid",    64'(rec_valid),   64'd0);
      check("rst_inst",     64'(inst_count),  64'd0);
      check("rst_cycle",    64'(cycle_count), 64'd0);
      check("rst_overflow", 64'(overflow),    64'd0);
      check("rst_proto",    64'(proto_err),   64'd0);
      check("rst_done",     64'(done),        64'd0);
      check("rst_fields",   obs_rec(),        64'd0);

      // Single REG write.
      rst        = 1'b0;
      rec_ready  = 1'b1;
      reg_write  = 1'b1;
      write_reg  = 4'd3;
      write_data = 16'h1234;
      tick();
      idle();
      check("reg_rec",   obs_rec(),         exp_rec(2'd0, 4'd3, 16'h0000, 16'h1234));
      check("reg_inst",  64'(inst_count),   64'd1);
      check("reg_cycle", 64'(cycle_count),  64'd1);

      // REG + LOAD in one cycle; load counts only through its register write.
      reg_write  = 1'b1;
      write_reg  = 4'd5;
      write_data = 16'h00AA;
      mem_read   = 1'b1;
      mem_addr   = 16'h0040;
      mem_rdata  = 16'hBEEF;
      tick();
      idle();
      check("pair_rec0", obs_rec(),       exp_rec(2'd0, 4'd5, 16'h0000, 16'h00AA));
      check("pair_inst", 64'(inst_count), 64'd2);
      tick();
      check("pair_rec1", obs_rec(),       exp_rec(2'd1, 4'd0, 16'h0040, 16'hBEEF));
      tick();
      check("pair_empty", 64'(rec_valid),   64'd0);
      check("pair_cycle", 64'(cycle_count), 64'd4);

      // Fill with stores while stalled; the 17th cycle is dropped.
      rec_ready = 1'b0;
      mem_write = 1'b1;
      mem_addr  = 16'h0010;
      for (int i = 0; i < 20; i++) begin
         mem_wdata = 16'h5500 + 16'(i);
         tick();
         if (i == 15) check("full_no_ovf", 64'(overflow), 64'd0);
         if (i == 16) check("full_ovf",    64'(overflow), 64'd1);
      end
      check("full_head", obs_rec(),       exp_rec(2'd2, 4'd0, 16'h0010, 16'h5500));
      check("full_inst", 64'(inst_count), 64'd22);

      // Push and pop together while full.
      rec_ready = 1'b1;
      mem_wdata = 16'h0077;
      tick();
      idle();
      check("full_pushpop", obs_rec(), exp_rec(2'd2, 4'd0, 16'h0010, 16'h5501));
      for (int k = 2; k < 16; k++) begin
         tick();
         check("drain_order", obs_rec(), exp_rec(2'd2, 4'd0, 16'h0010, 16'h5500 + 16'(k)));
      end
      tick();
      check("drain_last", obs_rec(), exp_rec(2'd2, 4'd0, 16'h0010, 16'h0077));
      tick();
      check("drain_empty",   64'(rec_valid),   64'd0);
      check("drain_inst",    64'(inst_count),  64'd23);
      check("drain_cycle",   64'(cycle_count), 64'd41);
      check("drain_ovf",     64'(overflow),    64'd1);
      check("pre_proto",     64'(proto_err),   64'd0);

      // Read and write together: STORE only, protocol error flagged.
      rec_ready = 1'b0;
      mem_read  = 1'b1;
      mem_write = 1'b1;
      mem_addr  = 16'h0020;
      mem_wdata = 16'h1111;
      mem_rdata = 16'h2222;
      tick();
      idle();
      check("rw_rec",   obs_rec(),        exp_rec(2'd2, 4'd0, 16'h0020, 16'h1111));
      check("rw_proto", 64'(proto_err),   64'd1);
      check("rw_inst",  64'(inst_count),  64'd24);
      rec_ready = 1'b1;
      tick();
      check("rw_single", 64'(rec_valid),  64'd0);

      // Reset with records queued.
      rec_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         reg_write  = 1'b1;
         write_reg  = 4'd1;
         write_data = 16'(i);
         tick();
      end
      idle();
      check("queued_valid", 64'(rec_valid), 64'd1);
      rst = 1'b1;
      tick();
      check("mrst_valid", 64'(rec_valid),   64'd0);
      check("mrst_inst",  64'(inst_count),  64'd0);
      check("mrst_cycle", 64'(cycle_count), 64'd0);
      check("mrst_ovf",   64'(overflow),    64'd0);
      check("mrst_proto", 64'(proto_err),   64'd0);
      check("mrst_done",  64'(done),        64'd0);

      // Seven commits, then HALT.
      rst       = 1'b0;
      rec_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         reg_write  = 1'b1;
         write_reg  = 4'd2;
         write_data = 16'h0100 + 16'(i);
         tick();
      end
      idle();
      rec_ready = 1'b0;
      halt      = 1'b1;
      pc        = 16'h002E;
      tick();
      idle();
      check("halt_inst",  64'(inst_count),  64'd8);
      check("halt_cycle", 64'(cycle_count), 64'd8);
      check("halt_done",  64'(done),        64'd0);
      reg_write  = 1'b1;
      write_reg  = 4'd9;
      write_data = 16'hFFFF;
      mem_write  = 1'b1;
      tick();
      tick();
      idle();
      check("frozen_inst",  64'(inst_count),  64'd8);
      check("frozen_cycle", 64'(cycle_count), 64'd8);
      check("halt_prev",    obs_rec(),        exp_rec(2'd0, 4'd2, 16'h0000, 16'h0106));
      rec_ready = 1'b1;
      tick();
      check("halt_rec",   obs_rec(),  exp_rec(2'd3, 4'd0, 16'h002E, 16'h0008));
      check("halt_busy",  64'(done),  64'd0);
      tick();
      check("halt_empty", 64'(rec_valid),  64'd0);
      check("halt_drain", 64'(done),       64'd1);
      check("final_inst", 64'(inst_count), 64'd8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/commit_trace_writer.md
Name: commit_trace_writer

Overview:
- Hardware producer of the processor's architectural commit trace.
- Samples the writeback/memory-stage commit signals of `cpu` every cycle and turns each event into a fixed-format record: REG write, LOAD, STORE or HALT.
- Buffers records in an internal FIFO and presents them in order on a valid/ready stream for an off-chip logger or a checker.
- Keeps instruction and cycle counts with the same counting rule used for the phase-2 simulation log.

Parameters:
- DEPTH, 16: FIFO entries; power of two, >= 4.
- PTR_W, 4: log2(DEPTH).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- reg_write  in  1  register file written this cycle.
- write_reg  in  4  destination register.
- write_data  in  16  data written to the register.
- mem_read  in  1  data-memory read this cycle.
- mem_write  in  1  data-memory write this cycle.
- mem_addr  in  16  data-memory address.
- mem_wdata  in  16  store data (into memory).
- mem_rdata  in  16  load data (out of memory).
- halt  in  1  HLT in MEM/WB this cycle.
- pc  in  16  current PC.
- rec_valid  out  1  head record available.
- rec_ready  in  1  consumer accepts head.
- rec_kind  out  2  0=REG, 1=LOAD, 2=STORE, 3=HALT.
- rec_reg  out  4  REG: write_reg; otherwise 0.
- rec_addr  out  16  LOAD/STORE: mem_addr; HALT: pc; REG: 0.
- rec_data  out  16  REG: write_data; LOAD: mem_rdata; STORE: mem_wdata; HALT: inst_count[15:0] after increment.
- inst_count  out  32  committed-instruction count.
- cycle_count  out  32  cycles since reset release.
- overflow  out  1  sticky; a cycle's events were dropped.
- proto_err  out  1  sticky; mem_read and mem_write both high.
- done  out  1  halted and FIFO drained.

Behaviour:
- Reset: all outputs 0, FIFO empty, state RUN. Reset mid-stream discards all buffered records.
- States:
  - RUN: sample inputs every cycle.
  - HALTED: entered on the cycle a HALT record is accepted into the FIFO. All commit inputs are ignored and counters freeze. Leave only via rst.
- Event set per RUN cycle, in push order:
  - REG if reg_write.
  - LOAD if mem_read & ~mem_write.
  - STORE if mem_write.
  - HALT if halt.
  - mem_read & mem_write together: STORE only, and proto_err is set.
  - At most 3 events per cycle; LOAD and STORE are exclusive.
- Push of n events (0..3):
  - Records are written to consecutive slots from wr_ptr in the order above; wr_ptr advances by n (mod DEPTH).
  - free = DEPTH - occupancy, where occupancy counts the pop happening in the same cycle.
  - If n > free: the whole cycle's events are dropped (never partial), overflow is set, and the counters still update.
  - If HALT is dropped, the state stays RUN and a later halt cycle retries.
- Pop: rec_valid = occupancy != 0. The head advances when rec_valid & rec_ready. Record fields are combinational from the head slot; zero read latency.
- A push into an empty FIFO is visible on rec_valid the next cycle; no same-cycle bypass.
- Simultaneous push and pop is allowed, including when full.
- Counters (RUN only):
  - cycle_count += 1 each cycle after reset.
  - inst_count += 1 if (halt | reg_write | mem_write). Same rule as the phase-2 log: loads count through their REG write, HALT counts once.
  - Both counters wrap modulo 2^32.
- done = (state == HALTED) & occupancy == 0.

Decomposition:
- Shared package `trace_pkg`:
  - kind encoding constants KIND_REG/LOAD/STORE/HALT.
  - record width 38 = {kind, reg, addr, data}.
  - record field offsets.
- One sub-module: `trace_fifo`, a DEPTH x 38 register array with up to 3 write ports (consecutive slots) and 1 read port. It exposes occupancy/free.
- The parent holds event compaction, the RUN/HALTED state, the counters and the sticky flags.

Test Plan:
- After reset, reg_write=1, write_reg=3, write_data=0x1234 for one cycle, rec_ready=1 -> next cycle one record {REG, 3, 0x0000, 0x1234}; inst_count=1.
- Same cycle: reg_write (r5=0x00AA) and mem_read at addr 0x0040 with rdata 0xBEEF -> two records in order REG then {LOAD, 0, 0x0040, 0xBEEF}; inst_count=1.
- mem_write at addr 0x0010, wdata 0x5555, with rec_ready=0 for 20 single-event cycles, DEPTH=16 -> 16 records held; cycle 17 dropped and overflow=1; occupancy stays 16; records drain in order once ready=1.
- mem_read=mem_write=1 -> exactly one STORE record; proto_err=1.
- halt=1 with pc=0x002E after 7 counted commits -> {HALT, 0, 0x002E, 0x0008}; later reg_write pulses are ignored; done=1 once drained; inst_count frozen at 8.
- rst asserted with 5 records queued -> next cycle rec_valid=0, counters 0, state RUN, overflow cleared.
